ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
//  Single-transfer AHB-Lite initiator. It converts a valid/ready command stream into NONSEQ word transfers
//  toward AHB-Lite peripherals such as the GPIO slave. Address and data phases are pipelined, so back-to-back
//  commands run at one transfer per cycle when HREADY=1. Each completed data phase returns one response
//  pulse carrying read data and error status. Used by test harnesses and small controllers as the bus driver.
// PARAMETERS
//  TIMEOUT_CYC  16  wait-state count at which HANG asserts (1..65535)
// PORTS
//  HCLK       in   1   clock, all state on rising edge
//  HRESETn    in   1   asynchronous active-low reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted this cycle when cmd_valid & cmd_ready
//  cmd_write  in   1   1=write, 0=read
//  cmd_addr   in   32  byte address; bits[1:0] ignored, driven as 00
//  cmd_wdata  in   32  write data; captured with the command
//  rsp_valid  out  1   one-cycle pulse per completed transfer (no back-pressure)
//  rsp_write  out  1   direction of the completed transfer
//  rsp_rdata  out  32  HRDATA sampled at completion; 0 for writes
//  rsp_err    out  1   HRESP was 1 at completion
//  HADDR      out  32  address-phase address
//  HTRANS     out  2   2'b10 NONSEQ when address phase valid, else 2'b00 IDLE
//  HWRITE     out  1   address-phase direction (0 when IDLE)
//  HSIZE      out  3   constant 3'b010 (word)
//  HBURST     out  3   constant 3'b000 (SINGLE)
//  HWDATA     out  32  data-phase write data (held until data phase completes)
//  HREADY     in   1   transfer-complete/bus-ready from the slave mux
//  HRESP      in   1   error response from the slave mux
//  HRDATA     in   32  read data from the slave mux
//  HANG       out  1   data phase stalled >= TIMEOUT_CYC cycles
// BEHAVIOUR
//  - Two stages: A (address phase: a_vld, a_wr, a_addr, a_wdata) and D (data phase: d_vld, d_wr, d_wdata).
//  - Reset (async): a_vld=d_vld=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_*=0,
//    HANG=0, wait counter=0. Reset asserted mid-transfer drops both stages; no response is produced.
//  - cmd_ready = !a_vld | HREADY (combinational). Accepted command loads A on the same edge.
//  - HTRANS/HADDR/HWRITE are driven directly from A. A is held stable while HREADY=0.
//  - At an edge with HREADY=1:
//    - A moves to D: d_vld<=a_vld; HWDATA<=a_wdata when a_wr.
//    - A is then refilled from the accepted command, or cleared to IDLE.
//    - If d_vld=1, the D transfer completes: next cycle rsp_valid=1, with rsp_write=d_wr,
//      rsp_rdata=(d_wr?0:HRDATA), rsp_err=HRESP.
//  - Latency: command accepted at edge N with the bus idle and zero waits -> address phase in cycle N..N+1,
//    data phase N+1..N+2, rsp_valid high in cycle N+2..N+3.
//  - Back-to-back: a command accepted every cycle gives one rsp_valid per cycle, in order.
//  - Wait states (HREADY=0): A, D and HWDATA are all frozen. No response is produced. cmd_ready=0 if a_vld.
//  - Error (two-cycle HRESP): the pending A transfer is not cancelled; HTRANS stays NONSEQ.
//    The errored transfer completes on the HREADY=1 cycle with rsp_err=1.
//  - HRESP=1 with HREADY=0 and d_vld=0 is ignored (slave protocol violation).
//  - Wait counter: increments each cycle with d_vld & !HREADY; saturates at 16'hFFFF.
//    Clears when HREADY=1 or d_vld=0. HANG = (count >= TIMEOUT_CYC). The transfer is never aborted.
//  - Simultaneous events: cmd accept + completion in the same cycle is the normal pipelined case.
//  - A read response uses HRDATA of the completing cycle only.
// TESTING
//  1 Write cmd addr=0x04 wdata=0x1, HREADY=1 -> HTRANS=10, HADDR=0x04, HWRITE=1 for 1 cycle;
//    HWDATA=0x1 next cycle; rsp_valid=1, rsp_err=0 one cycle later.
//  2 Write 0x00=0xA5A5 then read 0x00 back-to-back, slave returns 0xA5A5 -> HTRANS NONSEQ 2 consecutive cycles;
//    responses {write,0,0} then {read,0xA5A5,0} on consecutive cycles.
//  3 Read with HREADY low 3 cycles, TIMEOUT_CYC=2 -> HADDR/HWDATA stable, cmd_ready=0 if A full;
//    HANG rises after 2nd wait cycle; rsp_valid once when HREADY=1; HANG clears.
//  4 HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on write, next read queued -> rsp_err=1 for the write;
//    queued read still issued and completes with rsp_err=0.
//  5 HRESETn low while D busy and A full -> HTRANS=IDLE immediately (async), no rsp_valid;
//    after release a new command works normally.
//  6 cmd_valid=0 for 4 cycles -> HTRANS=00, HWRITE=0, no rsp_valid; HSIZE=010, HBURST=000 always.

Source files
------------

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - single-transfer AHB-Lite initiator with pipelined address/data phases
module ahb_lite_master #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic        HANG
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

    logic        a_vld;
    logic        a_wr;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        d_vld;
    logic        d_wr;
    logic [31:0] d_wdata;
    logic [15:0] wait_cnt;
    logic        cmd_accept;
    logic        d_done;

    assign cmd_ready  = !a_vld || HREADY;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign d_done     = HREADY && d_vld;

    assign HTRANS = a_vld ? 2'b10 : 2'b00;
    assign HADDR  = a_addr;
    assign HWRITE = a_vld && a_wr;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HWDATA = d_wdata;
    assign HANG   = (wait_cnt >= TIMEOUT_W);

    // Address stage: may fill whenever it is empty, otherwise only advances with HREADY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_vld   <= 1'b0;
            a_wr    <= 1'b0;
            a_addr  <= '0;
            a_wdata <= '0;
        end else if (HREADY || !a_vld) begin
            a_vld <= cmd_accept;
            if (cmd_accept) begin
                a_wr    <= cmd_write;
                a_addr  <= cmd_addr & 32'hFFFF_FFFC;
                a_wdata <= cmd_wdata;
            end
        end
    end

    // Data stage: frozen, including HWDATA, for the whole of any wait state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_vld   <= 1'b0;
            d_wr    <= 1'b0;
            d_wdata <= '0;
        end else if (HREADY) begin
            d_vld <= a_vld;
            d_wr  <= a_wr;
            if (a_vld && a_wr) begin
                d_wdata <= a_wdata;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_done;
            if (d_done) begin
                rsp_write <= d_wr;
                rsp_rdata <= d_wr ? 32'h0 : HRDATA;
                rsp_err   <= HRESP;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (d_vld && !HREADY) begin
            if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - directed bench for ahb_lite_master with TIMEOUT_CYC=2
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        HANG;

    int n_pass  = 0;
    int n_total = 0;

    ahb_lite_master #(.TIMEOUT_CYC(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .HANG      (HANG)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        HRDATA  = 32'h0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk1("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_hang", HANG, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        next_cyc();
        next_cyc();
        HRESETn = 1'b1;

        // Single write
        set_cmd(1'b1, 1'b1, 32'h04, 32'h1);
        mid();
        chk1("t1_cmd_ready", cmd_ready, 1'b1);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t1_htrans_a", 32'(HTRANS), 32'h2);
        chk("t1_haddr_a", HADDR, 32'h04);
        chk1("t1_hwrite_a", HWRITE, 1'b1);
        chk1("t1_rsp_early", rsp_valid, 1'b0);
        next_cyc();
        mid();
        chk("t1_htrans_d", 32'(HTRANS), 32'h0);
        chk1("t1_hwrite_d", HWRITE, 1'b0);
        chk("t1_hwdata", HWDATA, 32'h1);
        chk1("t1_rsp_d", rsp_valid, 1'b0);
        next_cyc();
        mid();
        chk1("t1_rsp_valid", rsp_valid, 1'b1);
        chk1("t1_rsp_write", rsp_write, 1'b1);
        chk1("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        next_cyc();
        mid();
        chk1("t1_rsp_pulse", rsp_valid, 1'b0);

        // Back-to-back write then read
        next_cyc();
        set_cmd(1'b1, 1'b1, 32'h00, 32'hA5A5);
        next_cyc();
        set_cmd(1'b1, 1'b0, 32'h00, 32'h0);
        mid();
        chk("t2_htrans_w", 32'(HTRANS), 32'h2);
        chk1("t2_hwrite_w", HWRITE, 1'b1);
        chk1("t2_cmd_ready", cmd_ready, 1'b1);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t2_htrans_r", 32'(HTRANS), 32'h2);
        chk1("t2_hwrite_r", HWRITE, 1'b0);
        chk("t2_haddr_r", HADDR, 32'h0);
        chk("t2_hwdata", HWDATA, 32'hA5A5);
        next_cyc();
        HRDATA = 32'hA5A5;
        mid();
        chk("t2_htrans_idle", 32'(HTRANS), 32'h0);
        chk1("t2_rsp1_valid", rsp_valid, 1'b1);
        chk1("t2_rsp1_write", rsp_write, 1'b1);
        chk("t2_rsp1_rdata", rsp_rdata, 32'h0);
        chk("t2_hwdata_hold", HWDATA, 32'hA5A5);
        next_cyc();
        HRDATA = 32'h0;
        mid();
        chk1("t2_rsp2_valid", rsp_valid, 1'b1);
        chk1("t2_rsp2_write", rsp_write, 1'b0);
        chk("t2_rsp2_rdata", rsp_rdata, 32'hA5A5);
        chk1("t2_rsp2_err", rsp_err, 1'b0);
        next_cyc();
        mid();
        chk1("t2_rsp_end", rsp_valid, 1'b0);

        // Read stalled by three wait states, write queued behind it
        next_cyc();
        set_cmd(1'b1, 1'b0, 32'h10, 32'h0);
        next_cyc();
        set_cmd(1'b1, 1'b1, 32'h14, 32'h77);
        next_cyc();
        set_cmd(1'b1, 1'b1, 32'h18, 32'h88);
        HREADY = 1'b0;
        mid();
        chk1("t3_w1_cmd_ready", cmd_ready, 1'b0);
        chk("t3_w1_haddr", HADDR, 32'h14);
        chk("t3_w1_htrans", 32'(HTRANS), 32'h2);
        chk1("t3_w1_hang", HANG, 1'b0);
        next_cyc();
        mid();
        chk1("t3_w2_hang", HANG, 1'b0);
        chk1("t3_w2_cmd_ready", cmd_ready, 1'b0);
        chk("t3_w2_haddr", HADDR, 32'h14);
        chk("t3_w2_hwdata", HWDATA, 32'hA5A5);
        chk1("t3_w2_rsp", rsp_valid, 1'b0);
        next_cyc();
        mid();
        chk1("t3_w3_hang", HANG, 1'b1);
        chk1("t3_w3_rsp", rsp_valid, 1'b0);
        chk("t3_w3_haddr", HADDR, 32'h14);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HREADY = 1'b1;
        HRDATA = 32'hDEAD_BEEF;
        mid();
        chk1("t3_done_cmd_ready", cmd_ready, 1'b1);
        chk1("t3_done_rsp", rsp_valid, 1'b0);
        next_cyc();
        HRDATA = 32'h1234_5678;
        mid();
        chk1("t3_rsp_valid", rsp_valid, 1'b1);
        chk1("t3_rsp_write", rsp_write, 1'b0);
        chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk1("t3_hang_clear", HANG, 1'b0);
        chk("t3_hwdata_wr", HWDATA, 32'h77);
        chk("t3_htrans_idle", 32'(HTRANS), 32'h0);
        next_cyc();
        HRDATA = 32'h0;
        mid();
        chk1("t3_wr_rsp_valid", rsp_valid, 1'b1);
        chk1("t3_wr_rsp_write", rsp_write, 1'b1);
        chk("t3_wr_rsp_rdata", rsp_rdata, 32'h0);
        next_cyc();
        mid();
        chk1("t3_rsp_end", rsp_valid, 1'b0);

        // Two-cycle error response on a write, read queued behind it
        next_cyc();
        set_cmd(1'b1, 1'b1, 32'h20, 32'h55);
        next_cyc();
        set_cmd(1'b1, 1'b0, 32'h24, 32'h0);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        mid();
        chk("t4_e1_htrans", 32'(HTRANS), 32'h2);
        chk("t4_e1_haddr", HADDR, 32'h24);
        chk("t4_e1_hwdata", HWDATA, 32'h55);
        chk1("t4_e1_rsp", rsp_valid, 1'b0);
        next_cyc();
        HREADY = 1'b1;
        mid();
        chk("t4_e2_htrans", 32'(HTRANS), 32'h2);
        chk("t4_e2_haddr", HADDR, 32'h24);
        next_cyc();
        HRESP  = 1'b0;
        HRDATA = 32'h0000_CAFE;
        mid();
        chk1("t4_wr_rsp_valid", rsp_valid, 1'b1);
        chk1("t4_wr_rsp_write", rsp_write, 1'b1);
        chk1("t4_wr_rsp_err", rsp_err, 1'b1);
        chk("t4_htrans_idle", 32'(HTRANS), 32'h0);
        next_cyc();
        HRDATA = 32'h0;
        mid();
        chk1("t4_rd_rsp_valid", rsp_valid, 1'b1);
        chk1("t4_rd_rsp_write", rsp_write, 1'b0);
        chk1("t4_rd_rsp_err", rsp_err, 1'b0);
        chk("t4_rd_rsp_rdata", rsp_rdata, 32'h0000_CAFE);

        // Asynchronous reset with both stages busy
        next_cyc();
        set_cmd(1'b1, 1'b1, 32'h30, 32'h99);
        next_cyc();
        set_cmd(1'b1, 1'b0, 32'h34, 32'h0);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        HREADY = 1'b0;
        #1;
        chk("t5_pre_htrans", 32'(HTRANS), 32'h2);
        chk("t5_pre_hwdata", HWDATA, 32'h99);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_htrans", 32'(HTRANS), 32'h0);
        chk("t5_rst_hwdata", HWDATA, 32'h0);
        chk1("t5_rst_hwrite", HWRITE, 1'b0);
        chk1("t5_rst_cmd_ready", cmd_ready, 1'b1);
        next_cyc();
        HREADY = 1'b1;
        mid();
        chk1("t5_rst_rsp1", rsp_valid, 1'b0);
        next_cyc();
        HRESETn = 1'b1;
        set_cmd(1'b1, 1'b1, 32'h40, 32'h1234);
        mid();
        chk1("t5_rel_rsp", rsp_valid, 1'b0);
        chk("t5_rel_htrans", 32'(HTRANS), 32'h0);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t5_new_htrans", 32'(HTRANS), 32'h2);
        chk("t5_new_haddr", HADDR, 32'h40);
        chk1("t5_new_rsp", rsp_valid, 1'b0);
        next_cyc();
        mid();
        chk("t5_new_hwdata", HWDATA, 32'h1234);
        chk1("t5_new_rsp_d", rsp_valid, 1'b0);
        next_cyc();
        mid();
        chk1("t5_new_rsp_valid", rsp_valid, 1'b1);
        chk1("t5_new_rsp_err", rsp_err, 1'b0);

        // Idle bus, including a stray HRESP with no transfer pending
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            HREADY = (i == 1) ? 1'b0 : 1'b1;
            HRESP  = (i == 1) ? 1'b1 : 1'b0;
            mid();
            chk("t6_htrans", 32'(HTRANS), 32'h0);
            chk1("t6_hwrite", HWRITE, 1'b0);
            chk1("t6_hang", HANG, 1'b0);
            chk("t6_hsize", 32'(HSIZE), 32'h2);
            chk("t6_hburst", 32'(HBURST), 32'h0);
            if (i > 0) chk1("t6_rsp", rsp_valid, 1'b0);
        end
        next_cyc();
        HREADY = 1'b1;
        HRESP  = 1'b0;
        mid();
        chk1("t6_stray_rsp", rsp_valid, 1'b0);

        // Low address bits are dropped
        next_cyc();
        set_cmd(1'b1, 1'b0, 32'h4B, 32'h0);
        next_cyc();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t7_haddr_align", HADDR, 32'h48);
        chk("t7_htrans", 32'(HTRANS), 32'h2);
        next_cyc();
        HRDATA = 32'h0BAD_F00D;
        next_cyc();
        HRDATA = 32'h0;
        mid();
        chk1("t7_rsp_valid", rsp_valid, 1'b1);
        chk("t7_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
